// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost thresholds and registered read data.
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wen,
    input  logic [DATA_W-1:0] datain,
    input  logic              ren,
    output logic [DATA_W-1:0] dataout,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] AF_T    = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_T    = (ADDR_W+1)'(AE_THRESH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]   rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] dataout_q, dataout_d;
    logic              rd_valid_q, rd_valid_d;
    logic              full_s, empty_s;
    logic              we_ok_s, re_ok_s;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full_s  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                     (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
    assign empty_s = (wptr_q == rptr_q);
    assign we_ok_s = wen & ~full_s;
    assign re_ok_s = ren & ~empty_s;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        dataout_d  = dataout_q;
        rd_valid_d = re_ok_s;
        if (we_ok_s) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        if (re_ok_s) begin
            rptr_d    = rptr_q + PTR_ONE;
            dataout_d = mem_q[rptr_q[ADDR_W-1:0]];
        end else begin
            rptr_d    = rptr_q;
            dataout_d = dataout_q;
        end
        case ({we_ok_s, re_ok_s})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            dataout_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            dataout_q  <= dataout_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage array is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we_ok_s) begin
            mem_q[wptr_q[ADDR_W-1:0]] <= datain;
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A new error in the same cycle as err_clr keeps the flag set.
    always_comb begin
        overflow_d  = (overflow_q  & ~err_clr) | (wen & full_s);
        underflow_d = (underflow_q & ~err_clr) | (ren & empty_s);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_err_clr_s;
    assign unused_err_clr_s = err_clr;
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign dataout      = dataout_q;
    assign rd_valid     = rd_valid_q;
    assign full         = full_s;
    assign empty        = empty_s;
    assign count        = count_q;
    assign almost_full  = (count_q >= AF_T);
    assign almost_empty = (count_q <= AE_T);

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised self-checking bench for sync_fifo_param against a queue-based occupancy model.
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wen = 1'b0;
    logic [DW-1:0] datain = '0;
    logic          ren = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] dataout;
    logic          rd_valid, full, empty, almost_full, almost_empty;
    logic [AW:0]   count;
    logic          overflow, underflow;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout = '0;
    logic          m_rv = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .datain(datain), .ren(ren),
        .dataout(dataout), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        int n;
        n = mq.size();
        chk("count",        32'(count),        32'(n));
        chk("empty",        32'(empty),        32'(n == 0));
        chk("full",         32'(full),         32'(n == DEPTH));
        chk("almost_full",  32'(almost_full),  32'(n >= DEPTH - 2));
        chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
        chk("dataout",      32'(dataout),      32'(m_dout));
        chk("rd_valid",     32'(rd_valid),     32'(m_rv));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_udf));
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout = '0;
        m_rv   = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    // One clock: drive on the falling edge, advance the model, check after the rising edge.
    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic clr);
        logic was_full, was_empty;
        @(negedge clk);
        wen = w; datain = d; ren = r; err_clr = clr;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        m_rv = r && !was_empty;
        if (m_rv) m_dout = mq.pop_front();
        if (w && !was_full) mq.push_back(d);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        m_ovf = (m_ovf && !clr) || (w && was_full);
        m_udf = (m_udf && !clr) || (r && was_empty);
`endif
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic drain();
        while (mq.size() > 0) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compare();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_dout",  32'(dataout), 32'h00);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Fill with 0x01..0x10 then read back in order.
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, DW'(i), 1'b0, 1'b0);
            if (i == 13) chk("af_at13", 32'(almost_full), 32'd0);
            if (i == 14) chk("af_at14", 32'(almost_full), 32'd1);
        end
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_count", 32'(count), 32'd16);
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            chk("rd_order", 32'(dataout), 32'(i));
            chk("rd_valid_lit", 32'(rd_valid), 32'd1);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("rv_drop", 32'(rd_valid), 32'd0);

        // Full with simultaneous read and write: the write is rejected.
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        chk("fullrw_count", 32'(count), 32'd15);
        chk("fullrw_full",  32'(full),  32'd0);
        chk("fullrw_dout",  32'(dataout), 32'h01);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("fullrw_next", 32'(dataout), 32'h02);
        drain();
        chk("fullrw_last", 32'(dataout), 32'h10);

        // Empty with simultaneous read and write: the read is rejected.
        cycle(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("emptyrw_count", 32'(count), 32'd1);
        chk("emptyrw_rv",    32'(rd_valid), 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("emptyrw_dout", 32'(dataout), 32'hAA);

        // Preload 3, then stream 40 words through both ports across the pointer wrap.
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(8'h30 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, DW'($urandom_range(0, 255)), 1'b1, 1'b0);
            chk("stream_count", 32'(count), 32'd3);
        end
        drain();

        // Error conditions; the model expects the flags only in the feature build.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        chk("ovf_count", 32'(count), 32'd16);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("ovf_lit", 32'(overflow), 32'd1);
`endif
        drain();
        cycle(1'b0, '0, 1'b1, 1'b0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("udf_lit", 32'(underflow), 32'd1);
`endif
        cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("clr_ovf", 32'(overflow),  32'd0);
        chk("clr_udf", 32'(underflow), 32'd0);

        // Randomised traffic with occasional error clears.
        for (int i = 0; i < 3000; i++) begin
            int mode;
            mode = (i / 500) % 3;
            cycle(($urandom_range(0, 99) < (mode == 0 ? 70 : (mode == 1 ? 30 : 50))),
                  DW'($urandom),
                  ($urandom_range(0, 99) < (mode == 0 ? 30 : (mode == 1 ? 70 : 50))),
                  ($urandom_range(0, 19) == 0));
        end

        // Asynchronous reset between clock edges mid-stream.
        for (int i = 0; i < 9; i++) cycle(1'b1, DW'($urandom), 1'b1, 1'b0);
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        @(negedge clk);
        wen = 1'b0; ren = 1'b0; err_clr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        chk("arst_count", 32'(count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++)
            cycle($urandom_range(0, 1) == 1, DW'($urandom), $urandom_range(0, 1) == 1, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
